mem_bus_unit: RTL and testbench
===============================

Name: mem_bus_unit

Overview:
- Unified memory stage directly downstream of the execution engine.
- Decodes the engine's 16-bit address, nRead and nWrite strobes into two regions:
  - Instruction memory: 0x8000-based, 32-bit words.
  - Data memory: 0x0000-based, 256-bit words.
- Returns registered read data on InstructDataOut and MemDataOut.
- Absorbs 256-bit writes from ExeDataOut, with a preload port for bench/boot loading and saturating access counters for debug.

Parameters:
- DATA_W, 256, width of data-memory words and of the ExeDataOut / MemDataOut / InstructDataOut buses.
- INSTR_W, 32, width of stored instruction words.
- DMEM_DEPTH, 16, number of data-memory words.
- IMEM_DEPTH, 16, number of instruction-memory words.
- CNT_W, 16, width of access counters.

Ports:
- Clk  input  1  clock, all state on rising edge.
- nReset  input  1  asynchronous, active-low reset.
- address  input  16  bus address from execution engine.
- nRead  input  1  active-low read strobe.
- nWrite  input  1  active-low write strobe.
- ExeDataOut  input  DATA_W  write data from execution engine.
- LoadEn  input  1  preload instruction word this cycle.
- LoadAddr  input  8  instruction-memory index for preload.
- LoadData  input  INSTR_W  preload instruction word.
- InstructDataOut  output  DATA_W  registered instruction read data, word in [31:0], [255:32]=0.
- MemDataOut  output  DATA_W  registered data-memory read data.
- AddrErr  output  1  one-cycle pulse: out-of-range access, or write to instruction region.
- BusErr  output  1  one-cycle pulse: nRead and nWrite both low.
- ReadCount  output  CNT_W  saturating count of accepted reads.
- WriteCount  output  CNT_W  saturating count of accepted writes.

Behaviour:
- Reset (nReset low, asynchronous):
  - InstructDataOut=0, MemDataOut=0, AddrErr=0, BusErr=0, ReadCount=0, WriteCount=0.
  - All data-memory words cleared to 0.
  - Instruction memory is NOT cleared.
  - LoadEn is ignored while nReset is low.
- Address decode:
  - address[15]=1 selects the instruction region; index = address[14:0], valid if < IMEM_DEPTH.
  - address[15]=0 selects the data region; index = address[14:0], valid if < DMEM_DEPTH.
- Read (nRead=0, nWrite=1 sampled at edge N):
  - Selected region's output register loads mem[index] at edge N, so data is valid after edge N, one-cycle latency.
  - The other region's output holds its previous value.
  - ReadCount increments.
- Output hold: while nRead=1, both output registers hold their last value. The engine may sample any later cycle.
- Write (nWrite=0, nRead=1 at edge N, data region, valid index):
  - dmem[index] <= ExeDataOut at edge N.
  - WriteCount increments.
  - Outputs unchanged.
- Write to the instruction region:
  - Ignored.
  - AddrErr=1 for the cycle after edge N.
  - WriteCount unchanged.
- Out-of-range read:
  - Selected output loads 0.
  - AddrErr pulses.
  - ReadCount unchanged.
- Out-of-range write: ignored, AddrErr pulses.
- Both strobes low:
  - Write is performed per the rules above.
  - Read is suppressed, outputs hold.
  - BusErr pulses; ReadCount unchanged.
- Write at edge N then read of the same index at edge N+1: returns the new data (no forwarding needed within a single edge).
- Preload (LoadEn=1, nReset=1):
  - imem[LoadAddr] <= LoadData.
  - Ignored if LoadAddr >= IMEM_DEPTH; AddrErr does not pulse for preload.
  - Preload is independent of the bus; simultaneous bus read of the same index returns the old word.
- Counters: saturate at all-ones, no wrap.
- Error pulses: AddrErr and BusErr are registered and deassert the following cycle unless re-triggered.
- Reset asserted mid-access: the access is abandoned and no memory write occurs on that edge.

Test Plan:
1. Preload imem[0]=0x10_03_01_02, then read address 0x8000 -> next cycle InstructDataOut[31:0]=0x10030102, upper bits 0, ReadCount=1.
2. Write 256'd7 to 0x0001 and 256'd5 to 0x0002, then read both -> MemDataOut=7, then 5; WriteCount=2, ReadCount=2.
3. Write 256'd12 to 0x0003, then read 0x0003 on the next cycle -> MemDataOut=12; hold nRead=1 for 5 cycles -> value stays 12.
4. Read 0x0010 (DMEM_DEPTH=16) -> MemDataOut=0, AddrErr high exactly one cycle. Write to 0x8001 -> imem unchanged, AddrErr pulse.
5. nRead=0 and nWrite=0 to 0x0004 with data 9 -> dmem[4]=9, outputs held, BusErr one-cycle pulse, ReadCount unchanged.
6. Write 0x0005, then assert nReset mid-write, then deassert -> all outputs 0, dmem[5]=0 on readback, imem contents preserved.

Source files
------------

// File: rtl/mem_bus_unit.sv
// Memory stage behind the execution engine: a 32-bit instruction region at 0x8000 and a
// 256-bit data region at 0x0000, with registered read ports and saturating access counters.
module mem_bus_unit #(
   parameter int DATA_W     = 256,
   parameter int INSTR_W    = 32,
   parameter int DMEM_DEPTH = 16,
   parameter int IMEM_DEPTH = 16,
   parameter int CNT_W      = 16
) (
   input  logic               Clk,
   input  logic               nReset,
   input  logic [15:0]        address,
   input  logic               nRead,
   input  logic               nWrite,
   input  logic [DATA_W-1:0]  ExeDataOut,
   input  logic               LoadEn,
   input  logic [7:0]         LoadAddr,
   input  logic [INSTR_W-1:0] LoadData,
   output logic [DATA_W-1:0]  InstructDataOut,
   output logic [DATA_W-1:0]  MemDataOut,
   output logic               AddrErr,
   output logic               BusErr,
   output logic [CNT_W-1:0]   ReadCount,
   output logic [CNT_W-1:0]   WriteCount
);

   localparam int DIDX_W = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
   localparam int IIDX_W = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
   localparam logic [14:0] DMEM_LIM = 15'(DMEM_DEPTH);
   localparam logic [14:0] IMEM_LIM = 15'(IMEM_DEPTH);
   localparam logic [8:0]  LOAD_LIM = 9'(IMEM_DEPTH);

   logic [DATA_W-1:0]  r_dmem [DMEM_DEPTH];
   logic [INSTR_W-1:0] r_imem [IMEM_DEPTH];
   logic [DATA_W-1:0]  r_instr_out;
   logic [DATA_W-1:0]  r_mem_out;
   logic               r_addr_err;
   logic               r_bus_err;
   logic [CNT_W-1:0]   r_read_cnt;
   logic [CNT_W-1:0]   r_write_cnt;

   logic               w_rd;
   logic               w_wr;
   logic               w_is_instr;
   logic               w_in_range;
   logic               w_rd_only;
   logic               w_dwr_ok;
   logic               w_addr_err;
   logic               w_load_ok;
   logic [DIDX_W-1:0]  w_didx;
   logic [IIDX_W-1:0]  w_iidx;
   logic [IIDX_W-1:0]  w_load_idx;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
   endfunction

   assign w_rd       = ~nRead;
   assign w_wr       = ~nWrite;
   assign w_is_instr = address[15];
   assign w_in_range = w_is_instr ? (address[14:0] < IMEM_LIM) : (address[14:0] < DMEM_LIM);
   assign w_didx     = address[DIDX_W-1:0];
   assign w_iidx     = address[IIDX_W-1:0];
   // A write strobe always takes priority; with both strobes low the read is dropped.
   assign w_rd_only  = w_rd & ~w_wr;
   assign w_dwr_ok   = w_wr & ~w_is_instr & w_in_range;
   assign w_addr_err = (w_wr & (w_is_instr | ~w_in_range)) | (w_rd_only & ~w_in_range);
   assign w_load_ok  = LoadEn & ({1'b0, LoadAddr} < LOAD_LIM);
   assign w_load_idx = LoadAddr[IIDX_W-1:0];

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         r_instr_out <= '0;
         r_mem_out   <= '0;
         r_addr_err  <= 1'b0;
         r_bus_err   <= 1'b0;
         r_read_cnt  <= '0;
         r_write_cnt <= '0;
         r_dmem      <= '{default: '0};
      end else begin
         r_addr_err <= w_addr_err;
         r_bus_err  <= w_rd & w_wr;
         if (w_rd_only) begin
            if (w_is_instr)
               r_instr_out <= w_in_range ? {{(DATA_W-INSTR_W){1'b0}}, r_imem[w_iidx]} : '0;
            else
               r_mem_out <= w_in_range ? r_dmem[w_didx] : '0;
            if (w_in_range)
               r_read_cnt <= sat_inc(r_read_cnt);
         end
         if (w_dwr_ok) begin
            r_dmem[w_didx] <= ExeDataOut;
            r_write_cnt    <= sat_inc(r_write_cnt);
         end
      end
   end

   // Instruction store keeps its contents across reset so boot code survives a reset.
   always_ff @(posedge Clk) begin
      if (nReset && w_load_ok)
         r_imem[w_load_idx] <= LoadData;
   end

   assign InstructDataOut = r_instr_out;
   assign MemDataOut      = r_mem_out;
   assign AddrErr         = r_addr_err;
   assign BusErr          = r_bus_err;
   assign ReadCount       = r_read_cnt;
   assign WriteCount      = r_write_cnt;

endmodule

// File: tb/tb_mem_bus_unit.sv
// Bench for mem_bus_unit: a vector table run through an expected-result queue, plus
// hand sequences for mid-access reset and counter saturation.
module tb_mem_bus_unit;

   localparam int DW = 256;
   localparam int CW = 4;

   logic          Clk;
   logic          nReset;
   logic [15:0]   address;
   logic          nRead;
   logic          nWrite;
   logic [DW-1:0] ExeDataOut;
   logic          LoadEn;
   logic [7:0]    LoadAddr;
   logic [31:0]   LoadData;
   logic [DW-1:0] InstructDataOut;
   logic [DW-1:0] MemDataOut;
   logic          AddrErr;
   logic          BusErr;
   logic [CW-1:0] ReadCount;
   logic [CW-1:0] WriteCount;

   mem_bus_unit #(.DATA_W(DW), .INSTR_W(32), .DMEM_DEPTH(16), .IMEM_DEPTH(16), .CNT_W(CW)) dut (
      .Clk(Clk), .nReset(nReset), .address(address), .nRead(nRead), .nWrite(nWrite),
      .ExeDataOut(ExeDataOut), .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData),
      .InstructDataOut(InstructDataOut), .MemDataOut(MemDataOut), .AddrErr(AddrErr),
      .BusErr(BusErr), .ReadCount(ReadCount), .WriteCount(WriteCount)
   );

   typedef struct {
      logic [15:0]   addr;
      logic          nrd;
      logic          nwr;
      logic [DW-1:0] wdata;
      logic          ld;
      logic [7:0]    ldaddr;
      logic [31:0]   lddata;
      logic [31:0]   e_instr;
      logic [DW-1:0] e_mem;
      logic          e_ae;
      logic          e_be;
      logic [CW-1:0] e_rc;
      logic [CW-1:0] e_wc;
   } vec_t;

   vec_t tbl [27];
   vec_t q [$];
   int   n_cmp = 0;
   int   n_err = 0;

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input logic [15:0] a, input logic nrd, input logic nwr,
                               input logic [DW-1:0] wd, input logic ld, input logic [7:0] la,
                               input logic [31:0] lv, input logic [31:0] ei, input logic [DW-1:0] em,
                               input logic ea, input logic eb, input logic [CW-1:0] rc,
                               input logic [CW-1:0] wc);
      vec_t v;
      v.addr = a; v.nrd = nrd; v.nwr = nwr; v.wdata = wd;
      v.ld = ld; v.ldaddr = la; v.lddata = lv;
      v.e_instr = ei; v.e_mem = em; v.e_ae = ea; v.e_be = eb; v.e_rc = rc; v.e_wc = wc;
      return v;
   endfunction

   task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic drive_idle();
      address = 16'h0; nRead = 1'b1; nWrite = 1'b1; ExeDataOut = '0;
      LoadEn = 1'b0; LoadAddr = 8'h0; LoadData = 32'h0;
   endtask

   task automatic apply(input vec_t v, input string tag);
      vec_t e;
      address = v.addr; nRead = v.nrd; nWrite = v.nwr; ExeDataOut = v.wdata;
      LoadEn = v.ld; LoadAddr = v.ldaddr; LoadData = v.lddata;
      q.push_back(v);
      @(posedge Clk);
      #1;
      e = q.pop_front();
      check({tag, " instr"}, InstructDataOut, {224'b0, e.e_instr});
      check({tag, " mem"},   MemDataOut, e.e_mem);
      check({tag, " aerr"},  DW'(AddrErr), DW'(e.e_ae));
      check({tag, " berr"},  DW'(BusErr), DW'(e.e_be));
      check({tag, " rcnt"},  DW'(ReadCount), DW'(e.e_rc));
      check({tag, " wcnt"},  DW'(WriteCount), DW'(e.e_wc));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " instr"}, InstructDataOut, '0);
      check({tag, " mem"},   MemDataOut, '0);
      check({tag, " aerr"},  DW'(AddrErr), '0);
      check({tag, " berr"},  DW'(BusErr), '0);
      check({tag, " rcnt"},  DW'(ReadCount), '0);
      check({tag, " wcnt"},  DW'(WriteCount), '0);
   endtask

   initial begin
      logic [31:0] i0;
      i0 = 32'h10030102;
      // addr nRd nWr wdata ld ldaddr lddata | instr mem ae be rc wc
      tbl[0]  = mk(16'h0000, 1, 1, 0,   1, 8'h00, 32'h10030102, 0,            0,  0, 0, 0, 0);
      tbl[1]  = mk(16'h0000, 1, 1, 0,   1, 8'h01, 32'hA5A50001, 0,            0,  0, 0, 0, 0);
      tbl[2]  = mk(16'h8000, 0, 1, 0,   0, 8'h00, 0,            i0,           0,  0, 0, 1, 0);
      tbl[3]  = mk(16'h0001, 1, 0, 7,   0, 8'h00, 0,            i0,           0,  0, 0, 1, 1);
      tbl[4]  = mk(16'h0002, 1, 0, 5,   0, 8'h00, 0,            i0,           0,  0, 0, 1, 2);
      tbl[5]  = mk(16'h0001, 0, 1, 0,   0, 8'h00, 0,            i0,           7,  0, 0, 2, 2);
      tbl[6]  = mk(16'h0002, 0, 1, 0,   0, 8'h00, 0,            i0,           5,  0, 0, 3, 2);
      tbl[7]  = mk(16'h0003, 1, 0, 12,  0, 8'h00, 0,            i0,           5,  0, 0, 3, 3);
      tbl[8]  = mk(16'h0003, 0, 1, 0,   0, 8'h00, 0,            i0,           12, 0, 0, 4, 3);
      for (int k = 9; k < 14; k++)
         tbl[k] = mk(16'h0000, 1, 1, 0, 0, 8'h00, 0,            i0,           12, 0, 0, 4, 3);
      tbl[14] = mk(16'h0010, 0, 1, 0,   0, 8'h00, 0,            i0,           0,  1, 0, 4, 3);
      tbl[15] = mk(16'h0000, 1, 1, 0,   0, 8'h00, 0,            i0,           0,  0, 0, 4, 3);
      tbl[16] = mk(16'h8001, 1, 0, 255, 0, 8'h00, 0,            i0,           0,  1, 0, 4, 3);
      tbl[17] = mk(16'h0000, 1, 1, 0,   0, 8'h00, 0,            i0,           0,  0, 0, 4, 3);
      tbl[18] = mk(16'h8001, 0, 1, 0,   0, 8'h00, 0,            32'hA5A50001, 0,  0, 0, 5, 3);
      tbl[19] = mk(16'h0004, 0, 0, 9,   0, 8'h00, 0,            32'hA5A50001, 0,  0, 1, 5, 4);
      tbl[20] = mk(16'h0000, 1, 1, 0,   0, 8'h00, 0,            32'hA5A50001, 0,  0, 0, 5, 4);
      tbl[21] = mk(16'h0004, 0, 1, 0,   0, 8'h00, 0,            32'hA5A50001, 9,  0, 0, 6, 4);
      tbl[22] = mk(16'h8000, 0, 1, 0,   1, 8'h00, 32'hDEADBEEF, i0,           9,  0, 0, 7, 4);
      tbl[23] = mk(16'h8000, 0, 1, 0,   0, 8'h00, 0,            32'hDEADBEEF, 9,  0, 0, 8, 4);
      tbl[24] = mk(16'h0000, 1, 1, 0,   1, 8'h10, 32'h00001234, 32'hDEADBEEF, 9,  0, 0, 8, 4);
      tbl[25] = mk(16'h8010, 0, 1, 0,   0, 8'h00, 0,            0,            9,  1, 0, 8, 4);
      tbl[26] = mk(16'h0000, 1, 1, 0,   0, 8'h00, 0,            0,            9,  0, 0, 8, 4);

      nReset = 1'b0;
      drive_idle();
      @(posedge Clk);
      @(posedge Clk);
      #1;
      check_all_zero("reset");
      nReset = 1'b1;

      for (int k = 0; k < 27; k++)
         apply(tbl[k], $sformatf("vec%0d", k));

      // Reset lands in the middle of a write cycle; that write must not happen.
      apply(mk(16'h0005, 1, 0, 256'h55, 0, 8'h00, 0, 0, 9, 0, 0, 8, 5), "wr5");
      address = 16'h0006; nRead = 1'b1; nWrite = 1'b0; ExeDataOut = 256'h66;
      #2;
      nReset = 1'b0;
      #1;
      check_all_zero("midrst");
      @(posedge Clk);
      #1;
      check_all_zero("inrst");
      nReset = 1'b1;
      drive_idle();

      apply(mk(16'h0005, 0, 1, 0, 0, 8'h00, 0, 0,            0, 0, 0, 1, 0), "rd5");
      apply(mk(16'h0006, 0, 1, 0, 0, 8'h00, 0, 0,            0, 0, 0, 2, 0), "rd6");
      apply(mk(16'h0001, 0, 1, 0, 0, 8'h00, 0, 0,            0, 0, 0, 3, 0), "rd1");
      apply(mk(16'h8001, 0, 1, 0, 0, 8'h00, 0, 32'hA5A50001, 0, 0, 0, 4, 0), "irdl");
      apply(mk(16'h8000, 0, 1, 0, 0, 8'h00, 0, 32'hDEADBEEF, 0, 0, 0, 5, 0), "ird0");

      for (int k = 0; k < 12; k++)
         apply(mk(16'h8000, 0, 1, 0, 0, 8'h00, 0, 32'hDEADBEEF, 0, 0, 0,
                  CW'((6 + k > 15) ? 15 : 6 + k), 0), $sformatf("rsat%0d", k));
      for (int k = 0; k < 17; k++)
         apply(mk(16'h0007, 1, 0, DW'(k), 0, 8'h00, 0, 32'hDEADBEEF, 0, 0, 0, 15,
                  CW'((k + 1 > 15) ? 15 : k + 1)), $sformatf("wsat%0d", k));
      apply(mk(16'h0007, 0, 1, 0, 0, 8'h00, 0, 32'hDEADBEEF, 256'd16, 0, 0, 15, 15), "rd7");

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
